// File: rtl/rca_pkg.sv
// Shared constants, FSM state type and sizing helper for the multi-precision RCA sequencer.
package rca_pkg;

  localparam int unsigned WORD_W = 32;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ADD  = 2'd1,
    DONE = 2'd2
  } state_t;

  // Word-index counter width; never narrower than one bit.
  function automatic int unsigned idx_width(input int unsigned words);
    return (words <= 1) ? 1 : $clog2(words);
  endfunction

endpackage

// File: rtl/rca_mp_seq_if.sv
// Operand/result handshake bundle for rca_mp_seq; master is the producer/consumer side.
interface rca_mp_seq_if import rca_pkg::*; #(
  parameter int unsigned WORDS = 4
);
  localparam int unsigned W = WORD_W * WORDS;

  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         cin;
  logic         op_sub;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] sum;
  logic         cout;
  logic         busy;

  modport master (
    output in_valid, a, b, cin, op_sub, out_ready,
    input  in_ready, out_valid, sum, cout, busy
  );

  modport slave (
    input  in_valid, a, b, cin, op_sub, out_ready,
    output in_ready, out_valid, sum, cout, busy
  );

endinterface

// File: rtl/rca_mp_seq_rca32.sv
// 32-bit ripple-carry adder; the single shared datapath of the sequencer.
module rca_32 import rca_pkg::*; (
  input  logic [WORD_W-1:0] a,
  input  logic [WORD_W-1:0] b,
  input  logic              cin,
  output logic [WORD_W-1:0] sum,
  output logic              cout
);

  logic c;

  // Carry ripples bit by bit from LSB to MSB.
  always_comb begin
    c   = cin;
    sum = '0;
    for (int i = 0; i < int'(WORD_W); i++) begin
      sum[i] = a[i] ^ b[i] ^ c;
      c      = (a[i] & b[i]) | (c & (a[i] ^ b[i]));
    end
    cout = c;
  end

endmodule

// File: rtl/rca_mp_seq.sv
// Multi-precision add/subtract: reuses one rca_32 for WORDS cycles, LS word first.
module rca_mp_seq import rca_pkg::*; #(
  parameter int unsigned WORDS = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  rca_mp_seq_if.slave bus
);

  localparam int unsigned W     = WORD_W * WORDS;
  localparam int unsigned IDX_W = idx_width(WORDS);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(WORDS - 1);

  state_t state, state_nxt;

  logic [IDX_W-1:0] idx_q;
  logic             carry_q;
  logic [W-1:0]     a_q;
  logic [W-1:0]     b_q;
  logic [W-1:0]     sum_q;
  logic             cout_q;
  logic             in_ready_q;
  logic             out_valid_q;
  logic             busy_q;

  logic             in_ready_d;
  logic             out_valid_d;
  logic             busy_d;

  logic [WORD_W-1:0] a_word;
  logic [WORD_W-1:0] b_word;
  logic [WORD_W-1:0] s_word;
  logic              c_word;
  logic              accept;
  logic              last_word;

  assign accept    = (state == IDLE) && bus.in_valid;
  assign last_word = (idx_q == IDX_LAST);
  assign a_word    = a_q[idx_q*WORD_W +: WORD_W];
  assign b_word    = b_q[idx_q*WORD_W +: WORD_W];

  rca_32 u_rca (
    .a    (a_word),
    .b    (b_word),
    .cin  (carry_q),
    .sum  (s_word),
    .cout (c_word)
  );

  // State register plus registered handshake flags.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state       <= IDLE;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state       <= state_nxt;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
      busy_q      <= busy_d;
    end
  end

  // Next-state logic.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (bus.in_valid)  state_nxt = ADD;
      ADD:     if (last_word)     state_nxt = DONE;
      DONE:    if (bus.out_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Flags are decoded from the upcoming state so they can be registered.
  always_comb begin
    in_ready_d  = 1'b0;
    out_valid_d = 1'b0;
    busy_d      = 1'b0;
    case (state_nxt)
      IDLE:    in_ready_d  = 1'b1;
      ADD:     busy_d      = 1'b1;
      DONE:    out_valid_d = 1'b1;
      default: in_ready_d  = 1'b1;
    endcase
  end

  // Operand capture and word-serial accumulation; subtract folds in as ~b + 1.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      idx_q   <= '0;
      carry_q <= 1'b0;
      a_q     <= '0;
      b_q     <= '0;
      sum_q   <= '0;
      cout_q  <= 1'b0;
    end else begin
      if (accept) begin
        a_q     <= bus.a;
        b_q     <= bus.op_sub ? ~bus.b : bus.b;
        carry_q <= bus.op_sub | bus.cin;
        idx_q   <= '0;
      end else if (state == ADD) begin
        sum_q[idx_q*WORD_W +: WORD_W] <= s_word;
        carry_q <= c_word;
        idx_q   <= idx_q + IDX_W'(1);
        if (last_word) begin
          cout_q <= c_word;
        end
      end
    end
  end

  assign bus.in_ready  = in_ready_q;
  assign bus.out_valid = out_valid_q;
  assign bus.busy      = busy_q;
  assign bus.sum       = sum_q;
  assign bus.cout      = cout_q;

endmodule

// File: tb/tb_rca_mp_seq.sv
// Directed-vector bench for rca_mp_seq with WORDS=4 (128-bit operands).
module tb_rca_mp_seq;

  localparam int unsigned WORDS = 4;
  localparam int unsigned W     = 128;

  logic clk;
  logic rst_n;
  int   checks;
  int   errors;

  rca_mp_seq_if #(.WORDS(WORDS)) bus ();

  rca_mp_seq #(.WORDS(WORDS)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Waits for out_valid after an accept edge and checks latency and result.
  task automatic wait_result(input string tag, input logic [W-1:0] es, input logic ec);
    int n;
    n = 0;
    while (!bus.out_valid && n < 20) begin
      tick();
      n++;
    end
    chk({tag, "_lat"}, W'(n), W'(WORDS));
    chk({tag, "_sum"}, bus.sum, es);
    chk({tag, "_cout"}, W'(bus.cout), W'(ec));
  endtask

  task automatic run_op(input string tag, input logic [W-1:0] av, input logic [W-1:0] bv,
                        input logic ci, input logic sb, input logic [W-1:0] es, input logic ec);
    bus.a         = av;
    bus.b         = bv;
    bus.cin       = ci;
    bus.op_sub    = sb;
    bus.in_valid  = 1'b1;
    bus.out_ready = 1'b0;
    chk({tag, "_rdy"}, W'(bus.in_ready), W'(1));
    tick();
    bus.in_valid = 1'b0;
    chk({tag, "_busy"}, W'(bus.busy), W'(1));
    wait_result(tag, es, ec);
    bus.out_ready = 1'b1;
    tick();
    bus.out_ready = 1'b0;
    chk({tag, "_ovdrop"}, W'(bus.out_valid), W'(0));
  endtask

  logic [W-1:0] ones;
  logic [W-1:0] held_sum;
  int           t1, t2, cyc;
  logic [W-1:0] r1, r2;
  int           ghost;

  initial begin
    checks        = 0;
    errors        = 0;
    ones          = '1;
    rst_n         = 1'b0;
    bus.in_valid  = 1'b0;
    bus.a         = '0;
    bus.b         = '0;
    bus.cin       = 1'b0;
    bus.op_sub    = 1'b0;
    bus.out_ready = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;

    chk("rst_in_ready", W'(bus.in_ready), W'(1));
    chk("rst_out_valid", W'(bus.out_valid), W'(0));
    chk("rst_sum", bus.sum, '0);
    chk("rst_cout", W'(bus.cout), W'(0));
    chk("rst_busy", W'(bus.busy), W'(0));

    run_op("ripple", ones, 128'd1, 1'b0, 1'b0, '0, 1'b1);
    run_op("wordcarry", 128'h0000_0000_0000_0000_0000_0000_FFFF_FFFF, 128'd1, 1'b0, 1'b0,
           128'h0000_0000_0000_0000_0000_0001_0000_0000, 1'b0);
    run_op("cin_only", '0, '0, 1'b1, 1'b0, 128'd1, 1'b0);
    run_op("sub_borrow", '0, 128'd1, 1'b0, 1'b1, ones, 1'b0);
    run_op("sub_borrow_cin", '0, 128'd1, 1'b1, 1'b1, ones, 1'b0);
    run_op("sub_5_3", 128'd5, 128'd3, 1'b0, 1'b1, 128'd2, 1'b1);
    run_op("sub_5_3_cin", 128'd5, 128'd3, 1'b1, 1'b1, 128'd2, 1'b1);
    run_op("topcarry", 128'h8000_0000_0000_0000_0000_0000_0000_0001,
           128'h8000_0000_0000_0000_0000_0000_0000_0002, 1'b0, 1'b0, 128'd3, 1'b1);

    // Back-pressure: result held, new request ignored until after the handshake.
    bus.a = 128'd100; bus.b = 128'd23; bus.cin = 1'b0; bus.op_sub = 1'b0;
    bus.in_valid = 1'b1; bus.out_ready = 1'b0;
    tick();
    bus.a = 128'd9; bus.b = 128'd9;
    wait_result("bp", 128'd123, 1'b0);
    held_sum = bus.sum;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("bp_hold_valid", W'(bus.out_valid), W'(1));
      chk("bp_hold_sum", bus.sum, 128'd123);
      chk("bp_hold_cout", W'(bus.cout), W'(0));
      chk("bp_hold_inrdy", W'(bus.in_ready), W'(0));
    end
    bus.out_ready = 1'b1;
    tick();
    bus.out_ready = 1'b0;
    chk("bp_hs_valid", W'(bus.out_valid), W'(0));
    chk("bp_hs_inrdy", W'(bus.in_ready), W'(1));
    chk("bp_hs_sum", bus.sum, held_sum);
    tick();
    bus.in_valid = 1'b0;
    chk("bp_accept_busy", W'(bus.busy), W'(1));
    chk("bp_accept_inrdy", W'(bus.in_ready), W'(0));
    wait_result("bp2", 128'd18, 1'b0);
    bus.out_ready = 1'b1;
    tick();
    bus.out_ready = 1'b0;

    // Reset while the third word is about to be processed.
    bus.a = ones; bus.b = ones; bus.cin = 1'b0; bus.op_sub = 1'b0;
    bus.in_valid = 1'b1;
    tick();
    bus.in_valid = 1'b0;
    tick();
    tick();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    chk("mid_rst_inrdy", W'(bus.in_ready), W'(1));
    chk("mid_rst_valid", W'(bus.out_valid), W'(0));
    chk("mid_rst_sum", bus.sum, '0);
    chk("mid_rst_cout", W'(bus.cout), W'(0));
    chk("mid_rst_busy", W'(bus.busy), W'(0));
    ghost = 0;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (bus.out_valid) ghost++;
    end
    chk("mid_rst_no_valid", W'(ghost), W'(0));

    // Back-to-back with out_ready tied high.
    bus.a = 128'd1; bus.b = 128'd2; bus.cin = 1'b0; bus.op_sub = 1'b0;
    bus.out_ready = 1'b1; bus.in_valid = 1'b1;
    tick();
    bus.a = 128'd7; bus.b = 128'd8;
    t1 = -1; t2 = -1; r1 = '0; r2 = '0;
    for (cyc = 1; cyc <= 20 && t2 < 0; cyc++) begin
      tick();
      if (bus.out_valid) begin
        if (t1 < 0) begin
          t1 = cyc; r1 = bus.sum;
        end else begin
          t2 = cyc; r2 = bus.sum; bus.in_valid = 1'b0;
        end
      end
    end
    bus.in_valid = 1'b0;
    chk("b2b_first_lat", W'(t1), W'(4));
    chk("b2b_first_sum", r1, 128'd3);
    chk("b2b_second_sum", r2, 128'd15);
    chk("b2b_gap", W'(t2 - t1), W'(6));
    tick();
    bus.out_ready = 1'b0;
    chk("b2b_idle", W'(bus.in_ready), W'(1));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/rca_mp_seq.md
Name: rca_mp_seq

Overview:
- Multi-precision add/subtract sequencer built around the team's 32-bit ripple-carry adder (RCA_32).
- Captures two WORDS×32-bit operands through a valid/ready handshake.
- Drives one shared RCA_32 instance for one word per cycle, least-significant word first, with the carry held in a register between words.
- Presents the full-width result and carry-out on a held valid/ready output; used wherever operands wider than 32 bits must reuse the single 32-bit adder.

Parameters:
- WORDS, 4, number of 32-bit words per operand (≥1); operand width W = 32*WORDS.

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  synchronous active-low reset.
- in_valid  in  1  operands/op present.
- in_ready  out  1  block can accept (high only in IDLE).
- a  in  W  operand A.
- b  in  W  operand B.
- cin  in  1  carry-in; ignored when op_sub=1.
- op_sub  in  1  0: A+B+cin; 1: A−B (A + ~B + 1).
- out_valid  out  1  result valid; held until accepted.
- out_ready  in  1  consumer accepts result.
- sum  out  W  result.
- cout  out  1  carry-out of the top word; for subtract, 1 = no borrow.
- busy  out  1  high in ADD.

Behaviour:
- Reset (rst_n=0 at a rising edge):
  - state=IDLE; word index, carry register, operand registers and sum register all cleared.
  - Outputs: in_ready=1, out_valid=0, sum=0, cout=0, busy=0.
  - Reset is honoured in any state, including mid-ADD and mid-DONE; any partial result is discarded and no out_valid pulse is produced.
- States: IDLE, ADD, DONE.
- IDLE:
  - in_ready=1.
  - On in_valid&in_ready: register a, b_eff (b when op_sub=0, ~b when op_sub=1) and carry = op_sub ? 1 : cin.
  - Clear the index; go to ADD.
- ADD (busy=1, in_ready=0):
  - Each cycle, RCA_32 adds a_reg[idx*32+:32], b_eff[idx*32+:32] and carry.
  - The sum word is written into sum_reg[idx*32+:32]; carry takes the RCA_32 cout.
  - idx increments each cycle; when idx==WORDS−1, latch the final carry into cout and go to DONE.
- DONE:
  - out_valid=1; sum and cout are held stable.
  - On out_ready: out_valid drops and the block returns to IDLE.
  - in_ready stays 0 in DONE, so a new operand is accepted no earlier than the cycle after the result handshake (no bypass).
- Latency: out_valid is asserted exactly WORDS cycles after the accepting cycle (WORDS=4 gives 4 cycles). Throughput is one operation per WORDS+2 cycles with out_ready tied high.
- Outputs are registered. sum and cout keep the last result through IDLE until the next DONE; they are undefined for consumers while out_valid=0.
- Arithmetic is modulo 2^W. The carry register is 1 bit; the index counter has width max(1,$clog2(WORDS)).
- WORDS=1 degenerates to one ADD cycle.
- Ignored inputs:
  - in_valid outside IDLE.
  - out_ready outside DONE.
- in_valid may be held high across cycles; only the IDLE-cycle handshake captures.

Decomposition:
- Shared package rca_pkg: WORD_W=32 constant, state enum type (IDLE/ADD/DONE), helper function for the index width.
- One sub-module: the existing RCA_32, instantiated once as the datapath.
- FSM, counter and registers live in rca_mp_seq.

Test Plan (WORDS=4, W=128):
- Full ripple: a=2^128−1, b=1, cin=0, op_sub=0 → sum=0, cout=1, out_valid exactly 4 cycles after accept.
- Word-boundary carry: a=0x0000_0000_0000_0000_0000_0000_FFFF_FFFF, b=1 → sum=0x...0000_0001_0000_0000, cout=0. Also cin=1 with a=b=0 → sum=1.
- Subtract with borrow: a=0, b=1, op_sub=1 → sum=2^128−1, cout=0. Also a=5, b=3, op_sub=1 → sum=2, cout=1; cin=1 must not change either result.
- Back-pressure: out_ready low for 5 cycles → out_valid, sum and cout held stable, in_ready=0 throughout. in_valid asserted during DONE is not accepted until the cycle after the out_ready handshake.
- Reset mid-operation: rst_n=0 for 1 cycle while idx=2 → next cycle state IDLE, in_ready=1, out_valid=0, sum=0, cout=0, and no out_valid ever appears for the aborted operation.
- Back-to-back with out_ready=1: two operations (1+2, then 7+8) → results 3 and 15 with out_valid pulses 6 cycles apart.
